rs_dec_seq_ctrl: RTL and testbench

- Parametrised sequencer for the RS decoder back end (key-equation solver -> Chien search -> Forney).
- Queues syndrome-complete frames, issues one-cycle start pulses to each stage in order, and reports per-frame done/fail.
- Adds capability checks, a zero-syndrome bypass and multi-frame queueing.
- Sits between the syndrome unit and the stage engines in the rs255_251 decoder, reusable for other T.

---
 rtl/rs_dec_seq_ctrl_if.sv | 36 +++
 rtl/rs_dec_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rs_dec_seq_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_dec_seq_ctrl_if.sv
// Handshake bundle between the syndrome unit, the RS back-end stage engines
// and the decoder sequencer.
interface rs_dec_seq_ctrl_if #(
    parameter int ERR_W = 3
);
    logic             din_sop;
    logic             din_eop;
    logic             syndrome_ok;
    logic             syndrome_zero;
    logic             euclid_ok;
    logic [ERR_W-1:0] error_num;
    logic             chien_ok;
    logic [ERR_W-1:0] chien_root_cnt;
    logic             forney_ok;
    logic             euclid_start;
    logic             chien_start;
    logic             forney_start;
    logic             dec_done;
    logic             dec_fail;
    logic             busy;
    logic             frame_overflow;

    modport master (
        output din_sop, din_eop, syndrome_ok, syndrome_zero, euclid_ok, error_num,
               chien_ok, chien_root_cnt, forney_ok,
        input  euclid_start, chien_start, forney_start, dec_done, dec_fail, busy,
               frame_overflow
    );

    modport slave (
        input  din_sop, din_eop, syndrome_ok, syndrome_zero, euclid_ok, error_num,
               chien_ok, chien_root_cnt, forney_ok,
        output euclid_start, chien_start, forney_start, dec_done, dec_fail, busy,
               frame_overflow
    );
endinterface

// File: rtl/rs_dec_seq_ctrl.sv
// RS decoder back-end sequencer: queues syndrome-complete frames and steps each through
// key-equation -> Chien -> Forney. Optional per-stage watchdog: define RS_DEC_WDOG_EN.
module rs_dec_seq_ctrl #(
    parameter int T        = 2,
    parameter int ERR_W    = 3,
    parameter int DEPTH    = 4,
    parameter int WDOG_CYC = 1023
) (
    input logic              clk,
    input logic              rst_n,
    rs_dec_seq_ctrl_if.slave bus
);
    localparam int               AW    = $clog2(DEPTH);
    localparam logic [AW:0]      FULL  = (AW+1)'(DEPTH);
    localparam logic [ERR_W-1:0] T_LIM = ERR_W'(T);

    typedef enum logic [2:0] {IDLE, EUC, CHN, FRN, RET} state_t;

    state_t           state;
    logic [DEPTH-1:0] q_mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [ERR_W-1:0] err_q;
    logic             in_frame;
    logic             bypass;
    logic             euc_start;
    logic             chn_start;
    logic             frn_start;
    logic             done;
    logic             fail;
    logic             busy_r;
    logic             ovf;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic head;
    logic euc_ok;
    logic chn_ok;
    logic frn_ok;
    logic err_bad;
    logic wd_exp;

    assign full    = (count == FULL);
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign push    = bus.syndrome_ok && (!full || pop);
    assign head    = q_mem[rd_ptr];
    // The start cycle of each stage never samples its own done strobe
    assign euc_ok  = bus.euclid_ok && !euc_start;
    assign chn_ok  = bus.chien_ok && !chn_start;
    assign frn_ok  = bus.forney_ok && !frn_start;
    assign err_bad = (bus.error_num > T_LIM) || (bus.error_num == '0);

`ifdef RS_DEC_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog;
    logic            any_start;

    assign any_start = euc_start || chn_start || frn_start;
    // The start cycle counts as cycle 1 of the stage
    assign wd_exp    = any_start ? (WDOG_CYC == 1) : (wdog == WD_W'(WDOG_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (any_start) begin
            wdog <= WD_W'(2);
        end else if (state == EUC || state == CHN || state == FRN) begin
            wdog <= wdog + WD_W'(1);
        end
    end
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYC != 0);
    assign wd_exp      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= bus.syndrome_zero;
        if (state == EUC && euc_ok) err_q <= bus.error_num;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_frame  <= 1'b0;
            bypass    <= 1'b0;
            euc_start <= 1'b0;
            chn_start <= 1'b0;
            frn_start <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            busy_r    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            euc_start <= 1'b0;
            chn_start <= 1'b0;
            frn_start <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            busy_r    <= in_frame || !empty || (state != IDLE);

            if (bus.din_eop) in_frame <= 1'b0;
            else if (bus.din_sop) in_frame <= 1'b1;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (bus.syndrome_ok && full && !pop) ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head) begin
                            state  <= RET;
                            bypass <= 1'b1;
                        end else begin
                            state     <= EUC;
                            euc_start <= 1'b1;
                        end
                    end
                end
                EUC: begin
                    if (euc_ok) begin
                        if (err_bad) begin
                            state <= RET;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end else begin
                            state     <= CHN;
                            chn_start <= 1'b1;
                        end
                    end else if (wd_exp) begin
                        state <= RET;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end
                end
                CHN: begin
                    if (chn_ok) begin
                        if (bus.chien_root_cnt != err_q) begin
                            state <= RET;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end else begin
                            state     <= FRN;
                            frn_start <= 1'b1;
                        end
                    end else if (wd_exp) begin
                        state <= RET;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end
                end
                FRN: begin
                    if (frn_ok) begin
                        state <= RET;
                        done  <= 1'b1;
                    end else if (wd_exp) begin
                        state <= RET;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end
                end
                RET: begin
                    // Stage verdicts were flagged on entry; a bypass frame retires here instead
                    state  <= IDLE;
                    done   <= bypass;
                    bypass <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.euclid_start   = euc_start;
    assign bus.chien_start    = chn_start;
    assign bus.forney_start   = frn_start;
    assign bus.dec_done       = done;
    assign bus.dec_fail       = fail;
    assign bus.busy           = busy_r;
    assign bus.frame_overflow = ovf;
endmodule

// File: tb/tb_rs_dec_seq_ctrl.sv
// Directed bench for rs_dec_seq_ctrl (T=2, ERR_W=3, DEPTH=4, WDOG_CYC=15).
module tb_rs_dec_seq_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    rs_dec_seq_ctrl_if #(.ERR_W(3)) bus ();

    rs_dec_seq_ctrl #(.T(2), .ERR_W(3), .DEPTH(4), .WDOG_CYC(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din_sop        = 1'b0;
        bus.din_eop        = 1'b0;
        bus.syndrome_ok    = 1'b0;
        bus.syndrome_zero  = 1'b0;
        bus.euclid_ok      = 1'b0;
        bus.error_num      = '0;
        bus.chien_ok       = 1'b0;
        bus.chien_root_cnt = '0;
        bus.forney_ok      = 1'b0;
    endtask

    // {euclid_start, chien_start, forney_start, dec_done, dec_fail, busy, frame_overflow}
    function automatic logic [6:0] outs();
        return {bus.euclid_start, bus.chien_start, bus.forney_start, bus.dec_done,
                bus.dec_fail, bus.busy, bus.frame_overflow};
    endfunction

    task automatic push_frame(input logic zero);
        bus.syndrome_ok   = 1'b1;
        bus.syndrome_zero = zero;
        tick();
        bus.syndrome_ok   = 1'b0;
        bus.syndrome_zero = 1'b0;
    endtask

    task automatic wait_euc(output int k);
        k = 0;
        while (bus.euclid_start !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (outs() !== 7'b0) begin fails++; $display("FAIL reset_outs: got %b expected %b", outs(), 7'b0); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (outs() !== 7'b0) begin fails++; $display("FAIL post_reset_idle: got %b expected %b", outs(), 7'b0); end
    endtask

    task automatic test_in_frame();
        bus.din_sop = 1'b1;
        tick();
        bus.din_sop = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL in_frame_busy: got %b expected 1", bus.busy); end
        bus.din_eop = 1'b1;
        tick();
        bus.din_eop = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL in_frame_eop: got %b expected 0", bus.busy); end
        bus.din_sop = 1'b1;
        bus.din_eop = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL one_symbol_frame: got %b expected 0", bus.busy); end
    endtask

    task automatic test_bypass();
        logic [2:0] starts;
        starts = '0;
        push_frame(1'b1);
        for (int n = 1; n <= 4; n++) begin
            starts |= {bus.euclid_start, bus.chien_start, bus.forney_start};
            checks++;
            if (bus.dec_done !== 1'(n == 3)) begin
                fails++; $display("FAIL bypass_done cyc%0d: got %b expected %b", n, bus.dec_done, n == 3);
            end
            if (n >= 2) begin
                checks++;
                if (bus.busy !== 1'(n != 4)) begin
                    fails++; $display("FAIL bypass_busy cyc%0d: got %b expected %b", n, bus.busy, n != 4);
                end
            end
            if (n == 3) begin
                checks++;
                if (bus.dec_fail !== 1'b0) begin fails++; $display("FAIL bypass_fail: got %b expected 0", bus.dec_fail); end
            end
            if (n < 4) tick();
        end
        checks++;
        if (starts !== 3'b000) begin fails++; $display("FAIL bypass_starts: got %b expected 000", starts); end
    endtask

    task automatic test_full_path();
        int k;
        push_frame(1'b0);
        wait_euc(k);
        checks++;
        if (bus.euclid_start !== 1'b1 || k != 1) begin
            fails++; $display("FAIL full_euc_start: got start=%b after %0d cycles expected 1 after 1", bus.euclid_start, k);
        end
        // Strobes in the start cycle or the wrong state must be ignored
        bus.euclid_ok = 1'b1; bus.error_num = 3'd0;
        bus.chien_ok  = 1'b1; bus.forney_ok = 1'b1;
        tick();
        checks++;
        if (outs() !== 7'b0000010) begin fails++; $display("FAIL full_ignore_early_ok: got %b expected %b", outs(), 7'b0000010); end
        bus.chien_ok  = 1'b0; bus.forney_ok = 1'b0;
        bus.euclid_ok = 1'b1; bus.error_num = 3'd2;
        tick();
        idle_inputs();
        checks++;
        if (outs() !== 7'b0100010) begin fails++; $display("FAIL full_chien_start: got %b expected %b", outs(), 7'b0100010); end
        tick();
        checks++;
        if (outs() !== 7'b0000010) begin fails++; $display("FAIL full_chien_width: got %b expected %b", outs(), 7'b0000010); end
        bus.chien_ok = 1'b1; bus.chien_root_cnt = 3'd2;
        tick();
        idle_inputs();
        checks++;
        if (outs() !== 7'b0010010) begin fails++; $display("FAIL full_forney_start: got %b expected %b", outs(), 7'b0010010); end
        tick();
        checks++;
        if (outs() !== 7'b0000010) begin fails++; $display("FAIL full_forney_width: got %b expected %b", outs(), 7'b0000010); end
        bus.forney_ok = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (outs() !== 7'b0001010) begin fails++; $display("FAIL full_done: got %b expected %b", outs(), 7'b0001010); end
        tick();
        tick();
        checks++;
        if (outs() !== 7'b0) begin fails++; $display("FAIL full_idle_after: got %b expected %b", outs(), 7'b0); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] mask;
        mask = '0;
        bus.syndrome_ok = 1'b1; bus.syndrome_zero = 1'b1;
        tick();
        tick();
        idle_inputs();
        for (int n = 2; n <= 8; n++) begin
            mask[n] = bus.dec_done;
            if (n < 8) tick();
        end
        checks++;
        if (mask !== 9'b000101000) begin fails++; $display("FAIL b2b_done_cycles: got %b expected %b", mask, 9'b000101000); end
    endtask

    task automatic test_euclid_fail();
        int k;
        logic seen;
        push_frame(1'b0);
        wait_euc(k);
        tick();
        bus.euclid_ok = 1'b1; bus.error_num = 3'd3;
        tick();
        idle_inputs();
        checks++;
        if ({bus.chien_start, bus.dec_done, bus.dec_fail} !== 3'b011) begin
            fails++; $display("FAIL euc_fail_done: got %b expected 011", {bus.chien_start, bus.dec_done, bus.dec_fail});
        end
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            seen |= bus.chien_start | bus.forney_start | bus.dec_done;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL euc_fail_quiet: got %b expected 0", seen); end
    endtask

    task automatic test_chien_mismatch();
        int k;
        logic seen;
        push_frame(1'b0);
        wait_euc(k);
        tick();
        bus.euclid_ok = 1'b1; bus.error_num = 3'd2;
        tick();
        idle_inputs();
        checks++;
        if (bus.chien_start !== 1'b1) begin fails++; $display("FAIL chn_mis_start: got %b expected 1", bus.chien_start); end
        tick();
        bus.chien_ok = 1'b1; bus.chien_root_cnt = 3'd1;
        tick();
        idle_inputs();
        checks++;
        if ({bus.forney_start, bus.dec_done, bus.dec_fail} !== 3'b011) begin
            fails++; $display("FAIL chn_mis_done: got %b expected 011", {bus.forney_start, bus.dec_done, bus.dec_fail});
        end
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            seen |= bus.forney_start | bus.dec_done;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL chn_mis_quiet: got %b expected 0", seen); end
    endtask

    task automatic test_overflow();
        logic [4:0] pat;
        logic [7:0] fbits;
        logic       pend;
        int         k, ndone, last, min_gap;
        push_frame(1'b0);
        wait_euc(k);
        pat = 5'b00111;
        for (int i = 0; i < 5; i++) begin
            bus.syndrome_ok = 1'b1; bus.syndrome_zero = pat[i];
            tick();
            if (i == 3) begin
                checks++;
                if (bus.frame_overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b expected 0", bus.frame_overflow); end
            end
        end
        idle_inputs();
        checks++;
        if (bus.frame_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", bus.frame_overflow); end
        ndone = 0; fbits = '0; last = -100; min_gap = 1000; pend = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.euclid_ok = pend;
            bus.error_num = '0;
            pend = bus.euclid_start;
            if (bus.dec_done === 1'b1) begin
                if (ndone < 8) fbits[ndone] = bus.dec_fail;
                if (i - last < min_gap) min_gap = i - last;
                last = i;
                ndone++;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (ndone != 5) begin fails++; $display("FAIL ovf_done_count: got %0d expected 5", ndone); end
        checks++;
        if (fbits[4:0] !== 5'b10001) begin fails++; $display("FAIL ovf_order: got %b expected %b", fbits[4:0], 5'b10001); end
        checks++;
        if (min_gap < 2) begin fails++; $display("FAIL ovf_spacing: got %0d expected >=2", min_gap); end
        checks++;
        if ({bus.frame_overflow, bus.busy} !== 2'b10) begin
            fails++; $display("FAIL ovf_sticky_idle: got %b expected 10", {bus.frame_overflow, bus.busy});
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic seen;
        push_frame(1'b0);
        wait_euc(k);
        push_frame(1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0) begin fails++; $display("FAIL reset_mid_outs: got %b expected %b", outs(), 7'b0); end
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            seen |= |outs();
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_abandon: got %b expected 0", seen); end
    endtask

`ifdef RS_DEC_WDOG_EN
    task automatic test_wdog();
        int k, done_at, euc_at;
        logic f;
        bus.syndrome_ok = 1'b1; bus.syndrome_zero = 1'b0;
        tick();
        tick();
        idle_inputs();
        wait_euc(k);
        tick();
        bus.euclid_ok = 1'b1; bus.error_num = 3'd1;
        tick();
        idle_inputs();
        checks++;
        if (bus.chien_start !== 1'b1) begin fails++; $display("FAIL wdog_chien_start: got %b expected 1", bus.chien_start); end
        done_at = -1; euc_at = -1; f = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (bus.dec_done === 1'b1 && done_at < 0) begin done_at = n; f = bus.dec_fail; end
            if (bus.euclid_start === 1'b1 && euc_at < 0) euc_at = n;
        end
        checks++;
        if (done_at != 15 || f !== 1'b1) begin
            fails++; $display("FAIL wdog_expire: got done at %0d fail %b expected 15 fail 1", done_at, f);
        end
        checks++;
        if (euc_at != 17) begin fails++; $display("FAIL wdog_next_frame: got %0d expected 17", euc_at); end
        for (int n = 0; n < 40; n++) tick();
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL wdog_drain: got %b expected 0", bus.busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_in_frame();
        test_bypass();
        test_full_path();
        test_back_to_back();
        test_euclid_fail();
        test_chien_mismatch();
        test_overflow();
        test_reset_mid();
`ifdef RS_DEC_WDOG_EN
        test_wdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
